led_trail_pwm: RTL and testbench

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_trail_cell.sv | 49 ++++
 rtl/led_trail_pwm.sv | 48 ++++
 tb/tb_led_trail_pwm.sv | 130 +++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared brightness constants and helpers for the LED trail PWM block
//   LED_PWM_BITS   default level width
//   LED_COUNT      number of LEDs per bank
//   level_max()    full-brightness level for a given width
//   half_level()   threshold below which the tail turns green as well
package led_pkg;
    localparam int LED_PWM_BITS = 4;
    localparam int LED_COUNT = 8;

    function automatic int level_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int half_level(input int bits);
        return 1 << (bits - 1);
    endfunction

    localparam int LED_LEVEL_MAX = level_max(LED_PWM_BITS);
    localparam int LED_HALF_LEVEL = half_level(LED_PWM_BITS);
endpackage

// File: rtl/led_trail_cell.sv
// led_trail_cell: one LED's brightness level, set/clear/decay update and PWM output
//   clk, reset     clock, asynchronous active-high reset
//   pattern_bit    head lit for this LED
//   trail_en       1 = decaying afterglow, 0 = hard on/off
//   decay_tick     one-cycle decay strobe shared by all cells
//   pwm_cnt        shared free-running PWM counter
//   led_r, led_g   registered red / green drive
module led_trail_cell
    import led_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pattern_bit,
    input  logic                trail_en,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_r,
    output logic                led_g
);
    localparam logic [PWM_BITS-1:0] LMAX = PWM_BITS'(level_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] HALF = PWM_BITS'(half_level(PWM_BITS));

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_next;
    logic                w_on;
    logic                w_dim;

    // Head wins over everything, including a coincident decay tick; decay saturates at 0
    assign w_next = pattern_bit ? LMAX :
                    !trail_en ? '0 :
                    (decay_tick && r_level != '0) ? r_level - PWM_BITS'(1) : r_level;
    // Full level is forced on so the head never flickers at pwm_cnt == LMAX
    assign w_on  = (r_level == LMAX) || (r_level > pwm_cnt);
    assign w_dim = r_level < HALF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
        end else begin
            r_level <= w_next;
            led_r   <= w_on;
            led_g   <= w_on && w_dim;
        end
    end
endmodule

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: 8-LED chaser with decaying PWM afterglow and tail colour shift
//   clk, reset     clock, asynchronous active-high reset
//   pattern_in     chaser pattern, bit i = LED i head lit
//   trail_en       1 = decaying afterglow trail, 0 = hard on/off
//   led_r, led_g   registered PWM drive for red / green banks
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS  = LED_PWM_BITS,
    parameter int DECAY_EXP = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LED_COUNT-1:0] pattern_in,
    input  logic                 trail_en,
    output logic [LED_COUNT-1:0] led_r,
    output logic [LED_COUNT-1:0] led_g
);
    logic [DECAY_EXP-1:0] r_presc;
    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic                 w_decay_tick;

    assign w_decay_tick = &r_presc;

    // Both counters wrap naturally at their width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc   <= r_presc + DECAY_EXP'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_cell
        led_trail_cell #(.PWM_BITS(PWM_BITS)) u_cell (
            .clk        (clk),
            .reset      (reset),
            .pattern_bit(pattern_in[i]),
            .trail_en   (trail_en),
            .decay_tick (w_decay_tick),
            .pwm_cnt    (r_pwm_cnt),
            .led_r      (led_r[i]),
            .led_g      (led_g[i])
        );
    end
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed self-checking bench for led_trail_pwm (PWM_BITS=4, DECAY_EXP=3)
module tb_led_trail_pwm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trail_en = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic [7:0] led_r;
    logic [7:0] led_g;
    logic [3:0] lv [8];
    int         n_pass = 0;
    int         n_tot = 0;
    int         h5 = 0;
    int         h0 = 0;

    always #5 clk = ~clk;

    led_trail_pwm #(.PWM_BITS(4), .DECAY_EXP(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .pattern_in(pattern_in),
        .trail_en  (trail_en),
        .led_r     (led_r),
        .led_g     (led_g)
    );

    for (genvar i = 0; i < 8; i++) begin : g_lv
        assign lv[i] = dut.g_cell[i].u_cell.r_level;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] lv_vec();
        return {lv[7], lv[6], lv[5], lv[4], lv[3], lv[2], lv[1], lv[0]};
    endfunction

    // Level of LED 0 after edge k of the first trail (head until edge 6, ticks on every 8th edge)
    function automatic int trail_lvl(input int k);
        int t;
        t = 15 - k / 8;
        return t < 0 ? 0 : t;
    endfunction

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_led_r", {24'd0, led_r}, 32'h0);
        chk("reset_led_g", {24'd0, led_g}, 32'h0);
        chk("reset_levels", lv_vec(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pattern_in = 8'h01;
        trail_en = 1'b1;
        @(negedge clk);
        chk("head_lvl_e1", {28'd0, lv[0]}, 32'd15);
        chk("head_led_r_e1", {24'd0, led_r}, 32'h0);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("head_lvl", {28'd0, lv[0]}, 32'd15);
            chk("head_led_r", {24'd0, led_r}, 32'h01);
            chk("head_led_g", {24'd0, led_g}, 32'h00);
        end
        pattern_in = 8'h00;
        for (int k = 7; k <= 140; k++) begin
            int  p;
            logic on;
            @(negedge clk);
            p = trail_lvl(k - 1);
            on = (p == 15) || (p > (k - 1) % 16);
            chk("trail_lvl", {28'd0, lv[0]}, trail_lvl(k));
            chk("trail_led_r", {31'd0, led_r[0]}, {31'd0, on});
            chk("trail_led_g", {31'd0, led_g[0]}, {31'd0, on && p < 8});
            if (k >= 81 && k <= 88) h5 += int'(led_r[0]);
            if (k >= 121) h0 += int'(led_r[0]);
        end
        chk("duty_lvl5", h5, 32'd5);
        chk("duty_lvl0", h0, 32'd0);
        pattern_in = 8'h0C;
        @(negedge clk);
        chk("set_bits32", lv_vec(), 32'h0000FF00);
        pattern_in = 8'h00;
        repeat (82) @(negedge clk);
        chk("decay_to5", lv_vec(), 32'h00005500);
        pattern_in = 8'h08;
        @(negedge clk);
        chk("set_wins_tick", lv_vec(), 32'h0000F400);
        pattern_in = 8'hFF;
        @(negedge clk);
        chk("all_set", lv_vec(), 32'hFFFFFFFF);
        pattern_in = 8'hC0;
        @(negedge clk);
        chk("hold_no_tick", lv_vec(), 32'hFFFFFFFF);
        trail_en = 1'b0;
        @(negedge clk);
        chk("trail_off_clear", lv_vec(), 32'hFF000000);
        @(negedge clk);
        chk("trail_off_led_r", {24'd0, led_r}, 32'hC0);
        chk("trail_off_led_g", {24'd0, led_g}, 32'h00);
        trail_en = 1'b1;
        pattern_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("pre_reset_lvl", lv_vec(), 32'hFF000000);
        chk("pre_reset_led_r", {24'd0, led_r}, 32'hC0);
        reset = 1'b1;
        #1;
        chk("mid_reset_led_r", {24'd0, led_r}, 32'h0);
        chk("mid_reset_led_g", {24'd0, led_g}, 32'h0);
        chk("mid_reset_lvl", lv_vec(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pattern_in = 8'h01;
        @(negedge clk);
        chk("post_reset_head", {28'd0, lv[0]}, 32'd15);
        pattern_in = 8'h00;
        repeat (6) @(negedge clk);
        chk("post_reset_e7", {28'd0, lv[0]}, 32'd15);
        @(negedge clk);
        chk("post_reset_tick_e8", {28'd0, lv[0]}, 32'd14);
        repeat (6) @(negedge clk);
        chk("post_reset_pwm_on", {24'd0, led_r}, 32'h01);
        @(negedge clk);
        chk("post_reset_pwm_off", {24'd0, led_r}, 32'h00);
        chk("post_reset_led_g", {24'd0, led_g}, 32'h00);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
